mem_interconnect: RTL
=====================

MEM_INTERCONNECT -- requirements
Module: mem_interconnect

Interface
REQ-001 Parameter NUM_SLAVES, default 6: number of slave ports; slave i is selected by m_addr[SEL_HI:SEL_LO] == i.
REQ-002 Parameter SEL_HI, default 15, and SEL_LO, default 12: bit range of the select field.
REQ-003 Parameter SYNC_MASK, default 6'b100111: bit i set means slave i is synchronous with fixed 1-cycle read latency and s_ready[i] is ignored; bit i clear means slave i drives s_ready[i].
REQ-004 Parameter TIMEOUT, default 255: maximum number of cycles spent waiting in ACCESS before an error completion (range 1..65535).
REQ-005 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on an error completion.
REQ-006 clk  in  1  single clock, all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-008 m_valid  in  1  master request; held high until m_ready.
REQ-009 m_addr  in  32  master byte address.
REQ-010 m_wstrb  in  4  byte write enables; 0 means read.
REQ-011 m_ready  out  1  single-cycle completion pulse.
REQ-012 m_rdata  out  32  read data; valid while m_ready is high.
REQ-013 s_cs  out  NUM_SLAVES  one-hot level select, high for the whole access.
REQ-014 s_stb  out  NUM_SLAVES  one-hot single-cycle pulse on the first access cycle only, for slaves with side effects (FIFOs).
REQ-015 s_wstrb  out  4*NUM_SLAVES  m_wstrb gated per slave by s_cs.
REQ-016 s_ready  in  NUM_SLAVES  ready inputs from the slaves.
REQ-017 s_rdata  in  32*NUM_SLAVES  flattened read data; slave i occupies bits [32i+31:32i].
REQ-018 bus_err  out  1  single-cycle pulse, coincident with m_ready, on an error completion.
REQ-019 err_addr  out  32  m_addr of the most recent error completion.
REQ-020 err_count  out  8  saturating count of error completions.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-022 IDLE: when m_valid is high, latch sel = m_addr[SEL_HI:SEL_LO], clear the wait counter, and go to ACCESS.
REQ-023 s_cs[sel] and s_wstrb SHALL be asserted only in ACCESS, from the latched sel.
REQ-024 s_stb[sel] SHALL be high only in the first ACCESS cycle.
REQ-025 Completion condition in ACCESS:
- SYNC_MASK[sel] set: the second ACCESS cycle.
- SYNC_MASK[sel] clear: s_ready[sel] high.
REQ-026 On completion: register m_rdata from s_rdata[sel], assert m_ready for the following cycle, and go to DONE.
REQ-027 Sync slave read latency SHALL be exactly 3 cycles, from m_valid sampled in IDLE to the m_ready cycle.
REQ-028 Async slave: m_ready SHALL be high in the cycle after the cycle in which s_ready[sel] was sampled high.
REQ-029 Error completion, for either of these cases:
- sel >= NUM_SLAVES: no s_cs is driven; completes after 1 ACCESS cycle.
- The wait counter reaches TIMEOUT with no completion.
On error completion: m_rdata = ERR_DATA, bus_err pulses, err_addr is updated and err_count increments (holding at 255).
REQ-030 DONE SHALL last exactly one cycle with s_cs low, then return to IDLE; a request is not accepted in DONE, so one transaction is never completed twice.
REQ-031 If m_valid falls while in ACCESS, the access is aborted: return to IDLE with no m_ready, no bus_err, and no change to the counters.
REQ-032 If completion and timeout occur in the same cycle, completion wins and no error is recorded.
REQ-033 m_rdata SHALL hold its last value outside m_ready cycles.
REQ-034 The wait counter width SHALL be $clog2(TIMEOUT+1).

Reset
REQ-035 While rst_n is low the block SHALL be in IDLE with the following outputs at 0: m_ready, s_cs, s_stb, s_wstrb, bus_err, m_rdata, err_addr, err_count.
REQ-036 Reset asserted mid-access SHALL abort the access at once; no m_ready is produced after deassertion until a new m_valid arrives.

Structure
REQ-037 The package mem_interconnect_pkg SHALL hold the state enum (IDLE/ACCESS/DONE) and the default ERR_DATA constant.
REQ-038 Select decode and the one-hot/gating generation SHALL be one sub-module, mem_addr_decode (purely combinational); the FSM, counters and error registers stay in mem_interconnect.

Verification
REQ-039 Sync read: slave 0 with s_rdata0 = 32'h1234_5678 and m_addr = 32'h0000_0010 -> m_ready exactly 3 cycles after m_valid, m_rdata = 32'h1234_5678, s_stb[0] high for 1 cycle.
REQ-040 Async write: slave 4 (SYNC_MASK bit clear), m_wstrb = 4'b0001, s_ready[4] raised after 5 cycles -> s_wstrb[19:16] = 4'b0001 throughout ACCESS, one m_ready, s_stb[4] high for exactly 1 cycle.
REQ-041 Timeout: TIMEOUT = 8 and slave 3 never ready -> m_ready and bus_err together, m_rdata = 32'hDEAD_BEEF, err_addr = m_addr, err_count = 1.
REQ-042 Unmapped: m_addr = 32'h0000_7000 with NUM_SLAVES = 6 -> no s_cs; error completion after 1 ACCESS cycle; err_count saturation checked with 260 such accesses -> 255.
REQ-043 Reset mid-access: rst_n pulsed low during ACCESS on slave 4 -> all outputs 0 immediately, no m_ready afterwards, and the next request completes normally.

Source files
------------

// File: rtl/mem_interconnect_pkg.sv
// Shared types and constants for the memory interconnect.
package mem_interconnect_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_addr_decode.sv
// Combinational slave decode: one-hot select/strobe, per-slave write gating
// and the read-data/ready/sync mux for the latched select.
module mem_addr_decode import mem_interconnect_pkg::*; #(
  parameter int                    NUM_SLAVES = 6,
  parameter int                    SEL_W      = 4,
  parameter logic [NUM_SLAVES-1:0] SYNC_MASK  = 6'b100111
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic                     active,
  input  logic                     first,
  input  logic [3:0]               wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [NUM_SLAVES-1:0]    s_cs,
  output logic [NUM_SLAVES-1:0]    s_stb,
  output logic [4*NUM_SLAVES-1:0]  s_wstrb,
  output logic                     hit,
  output logic                     sync,
  output logic                     rdy,
  output logic [31:0]              rdata
);
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    assign s_cs[i]          = active && (sel == IDX);
    assign s_stb[i]         = s_cs[i] && first;
    assign s_wstrb[4*i +: 4] = s_cs[i] ? wstrb : 4'b0000;
  end

  always_comb begin
    hit   = 1'b0;
    sync  = 1'b0;
    rdy   = 1'b0;
    rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) begin
        hit   = 1'b1;
        sync  = SYNC_MASK[i];
        rdy   = s_ready[i];
        rdata = s_rdata[32*i +: 32];
      end
    end
  end
endmodule

// File: rtl/mem_interconnect.sv
// Single-master to NUM_SLAVES interconnect: IDLE/ACCESS/DONE FSM with wait
// timeout, unmapped-address errors and a small error log.
module mem_interconnect import mem_interconnect_pkg::*; #(
  parameter int                    NUM_SLAVES = 6,
  parameter int                    SEL_HI     = 15,
  parameter int                    SEL_LO     = 12,
  parameter logic [NUM_SLAVES-1:0] SYNC_MASK  = 6'b100111,
  parameter int                    TIMEOUT    = 255,
  parameter logic [31:0]           ERR_DATA   = ERR_DATA_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_valid,
  input  logic [31:0]              m_addr,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_cs,
  output logic [NUM_SLAVES-1:0]    s_stb,
  output logic [4*NUM_SLAVES-1:0]  s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic                     bus_err,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);
  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m_ready_q, m_ready_d;
  logic               bus_err_q, bus_err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [7:0]         err_count_q, err_count_d;

  logic        dec_hit, dec_sync, dec_rdy;
  logic [31:0] dec_rdata;
  logic        in_access, first;

  assign in_access = (state_q == ACCESS);
  // Counter is cleared on entry, so zero marks the first ACCESS cycle.
  assign first     = in_access && (cnt_q == '0);

  mem_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W),
    .SYNC_MASK  (SYNC_MASK)
  ) u_dec (
    .sel     (sel_q),
    .active  (in_access),
    .first   (first),
    .wstrb   (m_wstrb),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .s_cs    (s_cs),
    .s_stb   (s_stb),
    .s_wstrb (s_wstrb),
    .hit     (dec_hit),
    .sync    (dec_sync),
    .rdy     (dec_rdy),
    .rdata   (dec_rdata)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    m_ready_d   = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: if (m_valid) begin
        sel_d   = m_addr[SEL_HI:SEL_LO];
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!m_valid) begin
          state_d = IDLE;
        end else if (dec_hit && (dec_sync ? (cnt_q == CNT_W'(1)) : dec_rdy)) begin
          // Checked before the timeout so a same-cycle completion wins.
          rdata_d   = dec_rdata;
          m_ready_d = 1'b1;
          state_d   = DONE;
        end else if (!dec_hit || (cnt_q == CNT_W'(TIMEOUT))) begin
          rdata_d     = ERR_DATA;
          m_ready_d   = 1'b1;
          bus_err_d   = 1'b1;
          err_addr_d  = m_addr;
          err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      m_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      m_ready_q   <= m_ready_d;
      bus_err_q   <= bus_err_d;
      rdata_q     <= rdata_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign m_ready   = m_ready_q;
  assign bus_err   = bus_err_q;
  assign m_rdata   = rdata_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
endmodule
